// File: rtl/sokoban_pkg.sv
// Shared types for the Sokoban input path: direction codes, scheduler FSM states, defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sokoban_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } state_t;

    localparam int DEF_ACK_TIMEOUT = 8;
    localparam int DEF_MIN_GAP     = 2;

    // Bit order of the one-hot vector is {right, left, down, up}.
    function automatic logic [3:0] dirOneHot(input dir_t d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO of 2-bit move codes with exact occupancy count and synchronous flush.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
module move_fifo
    import sokoban_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          flush,
    input  logic          push,
    input  dir_t          pushDat,
    input  logic          pop,
    output dir_t          popDat,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    dir_t          mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            if (doPush && !doPop)      level <= level + LW'(1);
            else if (doPop && !doPush) level <= level - LW'(1);
        end
    end

    // Storage needs no reset: the occupancy count gates every read.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushDat;
    end

    assign popDat = mem[rdPtr];
    assign full   = (level == LW'(DEPTH));
    assign empty  = (level == '0);

endmodule

// File: rtl/move_scheduler.sv
// Round-robin arbitrates key pulses into a FIFO and issues one move at a time to the game core.
// Latency: pulse sampled at edge t gives a one-cycle move pulse after edge t+1 (idle, empty FIFO).
// Backpressure: core busy / ack timeout / MIN_GAP hold the queue; drops set sticky overflow. MVS_VBLANK_SYNC_EN gates issue on vblank.
module move_scheduler
    import sokoban_pkg::*;
#(
    parameter  int FIFO_DEPTH  = 4,
    parameter  int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter  int MIN_GAP     = DEF_MIN_GAP,
    localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          MVS_clk,
    input  logic          MVS_rst,
    input  logic          MVS_clear,
    input  logic          MVS_up,
    input  logic          MVS_down,
    input  logic          MVS_left,
    input  logic          MVS_right,
    input  logic          MVS_core_busy,
    input  logic          MVS_vblank,
    output logic          MVS_dir_up,
    output logic          MVS_dir_down,
    output logic          MVS_dir_left,
    output logic          MVS_dir_right,
    output logic [1:0]    MVS_cmd_dir,
    output logic [LW-1:0] MVS_level,
    output logic          MVS_overflow
);

    localparam int TW = $clog2(ACK_TIMEOUT + 2);
    localparam int GW = $clog2(MIN_GAP + 2);

    state_t        state;
    state_t        stateNxt;
    logic [3:0]    req;
    logic          multiReq;
    logic          grantVld;
    dir_t          grantDir;
    dir_t          rrPtr;
    logic          popReq;
    logic          issueOk;
    logic          dropVld;
    logic          fifoFull;
    logic          fifoEmpty;
    dir_t          fifoDat;
    logic [TW-1:0] ackCnt;
    logic [TW-1:0] ackCntNxt;
    logic [GW-1:0] gapCnt;
    logic [GW-1:0] gapCntNxt;
    logic [3:0]    dirPulse;
    logic [3:0]    dirNxt;
    dir_t          cmdDir;
    dir_t          cmdNxt;
    logic          overflow;

    assign req      = {MVS_right, MVS_left, MVS_down, MVS_up};
    assign multiReq = |(req & (req - 4'd1));

    // The lowest offset from the pointer wins, so scan from the far end down.
    always_comb begin
        grantVld = 1'b0;
        grantDir = rrPtr;
        for (int i = 3; i >= 0; i--) begin
            if (req[rrPtr + 2'(i)]) begin
                grantVld = 1'b1;
                grantDir = rrPtr + 2'(i);
            end
        end
    end

`ifdef MVS_VBLANK_SYNC_EN
    assign issueOk = MVS_vblank;
`else
    logic unusedVblank;
    assign issueOk      = 1'b1;
    assign unusedVblank = MVS_vblank;
`endif

    assign popReq  = (state == IDLE) && !fifoEmpty && (gapCnt == '0) && issueOk;
    assign dropVld = grantVld && fifoFull && !popReq;

    move_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
        .clk     (MVS_clk),
        .rstN    (MVS_rst),
        .flush   (!MVS_clear),
        .push    (grantVld),
        .pushDat (grantDir),
        .pop     (popReq),
        .popDat  (fifoDat),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .level   (MVS_level)
    );

    always_ff @(posedge MVS_clk or negedge MVS_rst) begin
        if (!MVS_rst)        state <= IDLE;
        else if (!MVS_clear) state <= IDLE;
        else                 state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:      if (popReq) stateNxt = ISSUE;
            ISSUE:     stateNxt = WAIT_ACK;
            WAIT_ACK: begin
                if (MVS_core_busy)          stateNxt = WAIT_DONE;
                else if (ackCnt <= TW'(1))  stateNxt = GAP;
            end
            WAIT_DONE: if (!MVS_core_busy) stateNxt = GAP;
            GAP:       if (gapCnt <= GW'(1)) stateNxt = IDLE;
            default:   stateNxt = IDLE;
        endcase
    end

    always_comb begin
        ackCntNxt = ackCnt;
        gapCntNxt = gapCnt;
        dirNxt    = 4'b0000;
        cmdNxt    = cmdDir;
        case (state)
            IDLE: begin
                if (popReq) begin
                    dirNxt = dirOneHot(fifoDat);
                    cmdNxt = fifoDat;
                end
            end
            ISSUE: ackCntNxt = TW'(ACK_TIMEOUT);
            WAIT_ACK: begin
                if (ackCnt != '0) ackCntNxt = ackCnt - TW'(1);
                if (stateNxt == GAP) gapCntNxt = GW'(MIN_GAP);
            end
            WAIT_DONE: if (!MVS_core_busy) gapCntNxt = GW'(MIN_GAP);
            GAP: gapCntNxt = (gapCnt <= GW'(1)) ? '0 : gapCnt - GW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge MVS_clk or negedge MVS_rst) begin
        if (!MVS_rst) begin
            rrPtr    <= DIR_UP;
            ackCnt   <= '0;
            gapCnt   <= '0;
            dirPulse <= 4'b0000;
            cmdDir   <= DIR_UP;
            overflow <= 1'b0;
        end else if (!MVS_clear) begin
            rrPtr    <= DIR_UP;
            ackCnt   <= '0;
            gapCnt   <= '0;
            dirPulse <= 4'b0000;
            cmdDir   <= DIR_UP;
            overflow <= 1'b0;
        end else begin
            ackCnt   <= ackCntNxt;
            gapCnt   <= gapCntNxt;
            dirPulse <= dirNxt;
            cmdDir   <= cmdNxt;
            if (grantVld) rrPtr <= grantDir + 2'd1;
            if (multiReq || dropVld) overflow <= 1'b1;
        end
    end

    assign {MVS_dir_right, MVS_dir_left, MVS_dir_down, MVS_dir_up} = dirPulse;
    assign MVS_cmd_dir  = cmdDir;
    assign MVS_overflow = overflow;

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: directed scenarios then random traffic against an event-time model.
// Latency: n/a.
// Backpressure: the bench plays the core, choosing each move's busy window when it issues.
module tb_move_scheduler;

    localparam int DEPTH = 4;
    localparam int ACK   = 8;
    localparam int GAPC  = 2;

    logic       MVS_clk = 1'b0;
    logic       MVS_rst, MVS_clear;
    logic       MVS_up, MVS_down, MVS_left, MVS_right;
    logic       MVS_core_busy, MVS_vblank;
    logic       MVS_dir_up, MVS_dir_down, MVS_dir_left, MVS_dir_right;
    logic [1:0] MVS_cmd_dir;
    logic [2:0] MVS_level;
    logic       MVS_overflow;
    logic [3:0] dutDir;

    move_scheduler #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(ACK), .MIN_GAP(GAPC)) dut (
        .MVS_clk(MVS_clk), .MVS_rst(MVS_rst), .MVS_clear(MVS_clear),
        .MVS_up(MVS_up), .MVS_down(MVS_down), .MVS_left(MVS_left), .MVS_right(MVS_right),
        .MVS_core_busy(MVS_core_busy), .MVS_vblank(MVS_vblank),
        .MVS_dir_up(MVS_dir_up), .MVS_dir_down(MVS_dir_down),
        .MVS_dir_left(MVS_dir_left), .MVS_dir_right(MVS_dir_right),
        .MVS_cmd_dir(MVS_cmd_dir), .MVS_level(MVS_level), .MVS_overflow(MVS_overflow)
    );

    always #5 MVS_clk = ~MVS_clk;
    assign dutDir = {MVS_dir_right, MVS_dir_left, MVS_dir_down, MVS_dir_up};

    int         checks = 0;
    int         errors = 0;
    // Model: pending moves, arbitration pointer, sticky drop flag, and the earliest
    // edge at which the scheduler may take the next move off the queue.
    logic [1:0] mq[$];
    int         ptr;
    logic       ovf;
    logic [1:0] expCmd;
    logic [3:0] expPulse;
    int         edgeNo, readyEdge, busyFrom, busyTo;
    int         respMode, fixD, fixB;
    int         issueLog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset(input int firstEdge);
        mq.delete();
        ptr = 0; ovf = 1'b0; expCmd = 2'b00;
        readyEdge = firstEdge; busyFrom = 1; busyTo = 0;
    endtask

    // Core response to a move issued at edge e: a busy window starting d edges later
    // lasting b edges, or no response at all (ack timeout).
    task automatic respond(input int e);
        int d, b;
        if (respMode == 2 || (respMode == 0 && $urandom_range(0, 3) == 0)) begin
            readyEdge = e + 1 + ACK + GAPC + 1;
        end else begin
            d = (respMode == 1) ? fixD : $urandom_range(1, ACK);
            b = (respMode == 1) ? fixB : $urandom_range(1, 10);
            busyFrom  = e + 1 + d;
            busyTo    = e + d + b;
            readyEdge = e + 1 + d + b + GAPC + 1;
        end
    endtask

    task automatic step(input logic [3:0] req, input bit clr);
        int  e, g, nreq;
        bit  popped;
        e = edgeNo;
        {MVS_right, MVS_left, MVS_down, MVS_up} = req;
        MVS_clear     = ~clr;
        MVS_core_busy = (e >= busyFrom) && (e <= busyTo);
        @(posedge MVS_clk);
        expPulse = 4'b0000;
        if (clr) begin
            modelReset(e + 1);
        end else begin
            popped = (e >= readyEdge) && (mq.size() > 0);
`ifdef MVS_VBLANK_SYNC_EN
            popped = popped && MVS_vblank;
`endif
            if (popped) begin
                expCmd   = mq.pop_front();
                expPulse = 4'b0001 << expCmd;
                respond(e);
            end
            nreq = $countones(req);
            if (nreq > 0) begin
                g = -1;
                for (int i = 0; i < 4; i++)
                    if (g < 0 && req[(ptr + i) % 4]) g = (ptr + i) % 4;
                ptr = (g + 1) % 4;
                if (nreq > 1) ovf = 1'b1;
                if (mq.size() < DEPTH) mq.push_back(2'(g));
                else ovf = 1'b1;
            end
        end
        #1;
        chk("dir", 32'(dutDir), 32'(expPulse));
        chk("cmd_dir", 32'(MVS_cmd_dir), 32'(expCmd));
        chk("level", 32'(MVS_level), 32'(mq.size()));
        chk("overflow", 32'(MVS_overflow), 32'(ovf));
        if (dutDir != 4'b0000) issueLog.push_back(e);
        edgeNo++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0);
    endtask

    initial begin
        int n, cnt, r;
        logic [3:0] rq;
        MVS_rst = 1'b0; MVS_clear = 1'b1; MVS_core_busy = 1'b0; MVS_vblank = 1'b1;
        {MVS_right, MVS_left, MVS_down, MVS_up} = 4'b0000;
        respMode = 2; fixD = 1; fixB = 8;
        repeat (3) @(posedge MVS_clk);
        #3;
        chk("rst_dir", 32'(dutDir), 0);
        chk("rst_cmd", 32'(MVS_cmd_dir), 0);
        chk("rst_level", 32'(MVS_level), 0);
        chk("rst_overflow", 32'(MVS_overflow), 0);
        @(posedge MVS_clk); #1;
        MVS_rst = 1'b1;
        edgeNo = 0;
        modelReset(0);

        // Simultaneous up+right: up wins, right dropped; repeat lets right win.
        step(4'b1001, 1'b0);
        chk("ur_level", 32'(MVS_level), 1);
        chk("ur_overflow", 32'(MVS_overflow), 1);
        step(4'b0000, 1'b0);
        chk("ur_issue_up", 32'(dutDir), 32'(4'b0001));
        step(4'b1001, 1'b0);
        idle(20);
        chk("ur_second_right", 32'(MVS_cmd_dir), 3);

        // Single left with an 8-cycle busy window: one-edge latency, 13-cycle repeat.
        step(4'b0000, 1'b1);
        respMode = 1; fixD = 1; fixB = 8;
        n = edgeNo;
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        chk("left_latency", 32'(issueLog[issueLog.size() - 1]), 32'(n + 1));
        chk("left_cmd", 32'(MVS_cmd_dir), 2);
        step(4'b0100, 1'b0);
        idle(20);
        n = issueLog.size();
        chk("left_repeat", 32'(issueLog[n - 1] - issueLog[n - 2]), 13);

        // Six pulses under a long busy: queue saturates, then drains in order on timeouts.
        step(4'b0000, 1'b1);
        fixB = 40;
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        respMode = 2;
        step(4'b0001, 1'b0); step(4'b0010, 1'b0); step(4'b0100, 1'b0);
        step(4'b1000, 1'b0); step(4'b0001, 1'b0); step(4'b0010, 1'b0);
        chk("sat_level", 32'(MVS_level), 4);
        chk("sat_overflow", 32'(MVS_overflow), 1);
        idle(100);
        n = issueLog.size();
        chk("timeout_gap_a", 32'(issueLog[n - 1] - issueLog[n - 2]), 12);
        chk("timeout_gap_b", 32'(issueLog[n - 2] - issueLog[n - 3]), 12);

        // Clear while waiting on the core with two moves queued.
        step(4'b0000, 1'b1);
        respMode = 1; fixB = 30;
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b1000, 1'b0);
        idle(5);
        step(4'b0000, 1'b1);
        chk("clr_level", 32'(MVS_level), 0);
        chk("clr_overflow", 32'(MVS_overflow), 0);
        cnt = issueLog.size();
        idle(40);
        chk("clr_no_issue", 32'(issueLog.size()), 32'(cnt));

        // Async reset while the move pulse is high.
        respMode = 2;
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        chk("arst_pre", 32'(dutDir), 32'(4'b0001));
        #2 MVS_rst = 1'b0;
        #1;
        chk("arst_dir", 32'(dutDir), 0);
        chk("arst_level", 32'(MVS_level), 0);
        #3 MVS_rst = 1'b1;
        modelReset(edgeNo);

        // Random traffic with random core responses.
        respMode = 0;
        for (int k = 0; k < 3000; k++) begin
            r  = $urandom_range(0, 9);
            rq = (r < 6) ? 4'b0000 : (r < 9) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(1, 15));
            MVS_vblank = ($urandom_range(0, 3) != 0);
            step(rq, ($urandom_range(0, 499) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Sits between KEY_Driver and CORE_Gm.
- Arbitrates the four direction action pulses and buffers them in a small FIFO.
- Issues one move at a time to the game core, handshaking on the core's busy flag.
- Ensures no key press is lost while a move is being processed, and no two moves overlap.

Parameters:
- FIFO_DEPTH, 4: queued move entries; must be a power of 2, minimum 2.
- ACK_TIMEOUT, 8: cycles to wait for core busy to rise before treating the move as complete.
- MIN_GAP, 2: idle cycles forced between the end of one move and the next issue.

Ports:
- MVS_clk  in  1  system clock (25 MHz)
- MVS_rst  in  1  asynchronous reset, active low
- MVS_clear  in  1  synchronous local flush, active low (tied to level reset)
- MVS_up / MVS_down / MVS_left / MVS_right  in  1 each  single-cycle action pulses from key driver
- MVS_core_busy  in  1  high while core is executing a move
- MVS_vblank  in  1  high during vertical blanking; used only with the optional feature
- MVS_dir_up / MVS_dir_down / MVS_dir_left / MVS_dir_right  out  1 each  one-hot single-cycle move pulse to core
- MVS_cmd_dir  out  2  direction of the current/last issued move: 00 up, 01 down, 10 left, 11 right
- MVS_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- MVS_overflow  out  1  sticky; set when any request is dropped

Behaviour:
- Reset (MVS_rst=0, async):
  - all outputs 0; FIFO empty; FSM in IDLE; round-robin pointer = up; gap counter 0.
- Clear (MVS_clear=0, sampled each edge):
  - same effect as reset, synchronously.
  - Overrides every other event in that cycle, including mid-WAIT; the abandoned move is not reissued.
- Arbitration:
  - Multiple input pulses in one cycle: grant exactly one, round-robin starting from the pointer (order up, down, left, right).
  - After a grant, the pointer moves to the entry after the granted one.
  - Ungranted pulses are discarded and set MVS_overflow.
- FIFO:
  - Granted request is written on the same edge it is sampled.
  - Write when full and no pop that cycle: request dropped, MVS_overflow set.
  - Write when full with a simultaneous pop: request accepted; level unchanged.
  - MVS_level is always exact.
- FSM:
  - IDLE: if FIFO non-empty (and gap counter 0), pop the head, register the one-hot pulse and MVS_cmd_dir, go to ISSUE.
  - ISSUE: exactly one cycle with the pulse high; load timeout counter with ACK_TIMEOUT; go to WAIT_ACK.
  - WAIT_ACK:
    - MVS_core_busy=1: go to WAIT_DONE.
    - Counter reaching 0: treat as instant completion; go to GAP.
  - WAIT_DONE: on MVS_core_busy=0, go to GAP.
  - GAP: count MIN_GAP cycles, then go to IDLE. MIN_GAP=0 returns to IDLE next cycle.
- Latency: with an empty FIFO and FSM in IDLE, the input pulse at edge t produces the output pulse high in the cycle following edge t+1.
- Sustained input rate: at most one move per (1 + busy duration + MIN_GAP + 2) cycles.
- Outputs:
  - All outputs are registered.
  - At most one MVS_dir_* is high in any cycle.
  - MVS_cmd_dir holds its value until the next issue.

Optional Feature:
- Macro MVS_VBLANK_SYNC_EN.
- Defined: IDLE issues only when MVS_vblank=1. A pending move waits otherwise, so the board state never changes mid-frame and there is no tearing.
- Undefined: MVS_vblank is ignored; issue timing is as above.

Decomposition:
- Shared package sokoban_pkg:
  - 2-bit direction typedef and the constants DIR_UP/DOWN/LEFT/RIGHT.
  - FSM state enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP).
  - Default timeout constant.
- One sub-module: move_fifo. It is a synchronous FIFO with push/pop/full/empty/level, parameterised by depth, 2-bit data.

Test Plan:
- Single MVS_left pulse at cycle 10, core busy cycles 13-20 -> MVS_dir_left high only in cycle 12; MVS_cmd_dir=10; next issue no earlier than cycle 23.
- MVS_up and MVS_right pulsed in the same cycle after reset -> up queued; MVS_overflow=1, level=1. Repeat the same pulses -> right granted (pointer now at down, so right wins).
- Six pulses while core busy held high, FIFO_DEPTH=4 -> level saturates at 4, overflow=1; after busy drops, four moves issue in input order.
- Core never asserts busy -> each move completes after ACK_TIMEOUT=8 cycles plus gap; three queued moves issue 12 cycles apart.
- MVS_clear pulsed in WAIT_DONE with 2 entries queued -> next cycle level=0, overflow=0, no further pulses. Async MVS_rst mid-ISSUE clears the pulse immediately.
- With MVS_VBLANK_SYNC_EN, request while vblank=0 -> no pulse until the first cycle after vblank rises.
